game_flow_ctrl: RTL and testbench

Top-level game sequencer that drives the `start_game` and `animation` inputs of the character movement blocks and gates the collision `hit` vector they receive. It tracks remaining lives and times the intro, hit and invulnerability phases. It also reports game-over and win. It sits between the keyboard/collision logic and `donkey_movement` (and its opponent counterpart), in the 65 MHz pixel-clock domain.

---
 rtl/game_flow_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer. Runs the intro, play, hit-animation
// and grace phases. Counts down lives and gates collision hits. Every output is
// a flop, so no input has a combinational path to an output.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_MENU      | idle after reset; waits for a start edge
// ST_INTRO     | intro animation; movement frozen, hits dropped
// ST_PLAY      | live play; hits cost a life, win ends the game
// ST_HIT_ANIM  | hit animation; movement frozen, hits dropped
// ST_GRACE     | post-hit invulnerability; hits dropped, win still counts
// ST_GAME_OVER | out of lives; waits for a start edge
// ST_WIN       | goal reached; waits for a start edge
module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int ANIM_CYCLES  = 32_500_000,
    parameter int GRACE_CYCLES = 65_000_000,
    parameter int TIMER_W      = 27
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_btn,
    input  logic [9:0]                   hit,
    input  logic                         win,
    output logic                         start_game,
    output logic                         animation,
    output logic [9:0]                   hit_out,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic                         game_over,
    output logic                         game_won
);

    localparam int LW = $clog2(LIVES + 1);
    localparam logic [TIMER_W-1:0] ANIM_LOAD  = TIMER_W'(ANIM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GRACE_LOAD = TIMER_W'(GRACE_CYCLES - 1);
    localparam logic [LW-1:0]      LIVES_LOAD = LW'(LIVES);

    typedef enum logic [2:0] {
        ST_MENU,
        ST_INTRO,
        ST_PLAY,
        ST_HIT_ANIM,
        ST_GRACE,
        ST_GAME_OVER,
        ST_WIN
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LW-1:0]        lives_q, lives_d;
    logic                 start_btn_q;
    logic                 start_game_q, start_game_d;
    logic                 animation_q, animation_d;
    logic [9:0]           hit_out_q, hit_out_d;
    logic                 game_over_q, game_over_d;
    logic                 game_won_q, game_won_d;
    logic                 start_edge;
    logic                 timer_zero;

    assign start_edge = start_btn & ~start_btn_q;
    assign timer_zero = (timer_q == '0);

    // Next state, phase timer and lives; output flags follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lives_d   = lives_q;
        hit_out_d = '0;
        unique case (state_q)
            ST_MENU, ST_GAME_OVER, ST_WIN: begin
                if (start_edge) begin
                    lives_d = LIVES_LOAD;
                    timer_d = ANIM_LOAD;
                    state_d = ST_INTRO;
                end
            end
            ST_INTRO: begin
                if (timer_zero) state_d = ST_PLAY;
                else            timer_d = timer_q - 1'b1;
            end
            ST_PLAY: begin
                if (win) begin
                    state_d = ST_WIN;
                end else if (|hit) begin
                    hit_out_d = hit;
                    if (lives_q != '0) lives_d = lives_q - 1'b1;
                    if (lives_q <= LW'(1)) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        timer_d = ANIM_LOAD;
                        state_d = ST_HIT_ANIM;
                    end
                end
            end
            ST_HIT_ANIM: begin
                if (timer_zero) begin
                    timer_d = GRACE_LOAD;
                    state_d = ST_GRACE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GRACE: begin
                if (win)             state_d = ST_WIN;
                else if (timer_zero) state_d = ST_PLAY;
                else                 timer_d = timer_q - 1'b1;
            end
            default: state_d = ST_MENU;
        endcase

        start_game_d = (state_d == ST_INTRO) || (state_d == ST_PLAY) ||
                       (state_d == ST_HIT_ANIM) || (state_d == ST_GRACE);
        animation_d  = (state_d == ST_INTRO) || (state_d == ST_HIT_ANIM);
        game_over_d  = (state_d == ST_GAME_OVER);
        game_won_d   = (state_d == ST_WIN);
    end

    // State, timer, lives and registered outputs; reset aborts any phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_MENU;
            timer_q      <= '0;
            lives_q      <= '0;
            start_btn_q  <= 1'b0;
            start_game_q <= 1'b0;
            animation_q  <= 1'b0;
            hit_out_q    <= '0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives_q      <= lives_d;
            start_btn_q  <= start_btn;
            start_game_q <= start_game_d;
            animation_q  <= animation_d;
            hit_out_q    <= hit_out_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    assign start_game = start_game_q;
    assign animation  = animation_q;
    assign hit_out    = hit_out_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;
    assign game_won   = game_won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by random play, all
// predicted by a cycle-count game model and checked by a queue-based monitor.
module tb_game_flow_ctrl;

    localparam int L     = 3;
    localparam int ANIM  = 4;
    localparam int GRACE = 6;
    localparam int LW    = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_btn = 1'b0;
    logic [9:0]    hit = '0;
    logic          win = 1'b0;
    logic          start_game, animation, game_over, game_won;
    logic [9:0]    hit_out;
    logic [LW-1:0] lives;

    int total = 0;
    int bad   = 0;

    game_flow_ctrl #(
        .LIVES(L), .ANIM_CYCLES(ANIM), .GRACE_CYCLES(GRACE), .TIMER_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .hit(hit), .win(win),
        .start_game(start_game), .animation(animation), .hit_out(hit_out),
        .lives(lives), .game_over(game_over), .game_won(game_won)
    );

    always #5 clk = ~clk;

    // Expected output word: {start_game, animation, hit_out, lives, game_over, game_won}
    typedef logic [LW+13:0] obs_t;
    obs_t exp_q[$];

    // Game model: mode + remaining-cycle counters for animation and grace.
    localparam int M_MENU = 0, M_RUN = 1, M_OVER = 2, M_WON = 3;
    int         m_mode, m_anim_left, m_grace_left, m_lives;
    bit         m_grace_pending, m_prev_btn;
    logic [9:0] m_hit_out;

    function automatic obs_t dut_obs();
        return {start_game, animation, hit_out, lives, game_over, game_won};
    endfunction

    task automatic model_reset();
        m_mode = M_MENU; m_anim_left = 0; m_grace_left = 0; m_lives = 0;
        m_grace_pending = 0; m_prev_btn = 0; m_hit_out = '0;
    endtask

    task automatic model_step(input bit sb, input logic [9:0] h, input bit w);
        bit edge_seen;
        edge_seen = sb && !m_prev_btn;
        m_prev_btn = sb;
        m_hit_out = '0;
        if (m_mode != M_RUN) begin
            if (edge_seen) begin
                m_mode = M_RUN; m_lives = L; m_anim_left = ANIM;
                m_grace_left = 0; m_grace_pending = 0;
            end
        end else if (m_anim_left > 0) begin
            m_anim_left--;
            if (m_anim_left == 0 && m_grace_pending) begin
                m_grace_left = GRACE;
                m_grace_pending = 0;
            end
        end else if (w) begin
            m_mode = M_WON;
        end else if (m_grace_left > 0) begin
            m_grace_left--;
        end else if (h != 0) begin
            m_hit_out = h;
            m_lives--;
            if (m_lives == 0) m_mode = M_OVER;
            else begin
                m_anim_left = ANIM;
                m_grace_pending = 1;
            end
        end
    endtask

    function automatic obs_t model_obs();
        logic [LW-1:0] lv;
        lv = LW'(m_lives);
        return {m_mode == M_RUN, (m_mode == M_RUN) && (m_anim_left > 0),
                m_hit_out, lv, m_mode == M_OVER, m_mode == M_WON};
    endfunction

    // One stimulus cycle: drive inputs away from the edge, predict, enqueue.
    task automatic cyc(input bit sb, input logic [9:0] h, input bit w);
        @(negedge clk);
        start_btn = sb; hit = h; win = w;
        model_step(sb, h, w);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 10'h000, 1'b0);
    endtask

    task automatic start_pulse();
        cyc(1'b1, 10'h000, 1'b0);
        cyc(1'b0, 10'h000, 1'b0);
    endtask

    // Monitor: one registered response per stimulus cycle, compared after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got sg=%b an=%b ho=%h lv=%0d go=%b gw=%b want sg=%b an=%b ho=%h lv=%0d go=%b gw=%b",
                             $time, a[LW+13], a[LW+12], a[LW+11:LW+2], a[LW+1:2], a[1], a[0],
                             e[LW+13], e[LW+12], e[LW+11:LW+2], e[LW+1:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int hold;
        logic [9:0] hv;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle in menu, then start sequence and intro.
        idle(100);
        start_pulse();
        idle(6);

        // Held hit: one life, full anim + grace, then the held hit bites again
        // and eventually ends the game.
        for (int i = 0; i < 40; i++) cyc(1'b0, 10'h004, 1'b0);
        idle(3);
        start_pulse();
        idle(5);

        // Win and hit in the same play cycle.
        cyc(1'b0, 10'h001, 1'b1);
        idle(3);
        start_pulse();
        idle(5);

        // Win during grace.
        cyc(1'b0, 10'h200, 1'b0);
        idle(ANIM + 2);
        cyc(1'b0, 10'h000, 1'b1);
        idle(3);
        start_pulse();
        idle(5);

        // Asynchronous reset mid hit-animation.
        cyc(1'b0, 10'h0F0, 1'b0);
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0; start_btn = 1'b0; hit = '0; win = 1'b0;
        #1;
        total++;
        if (dut_obs() !== '0) begin
            bad++;
            $display("FAIL async_reset got %h want 0", dut_obs());
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Random play.
        hold = 0;
        hv = '0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0 && $urandom_range(0, 9) == 0) begin
                hold = $urandom_range(1, 12);
                hv = 10'($urandom);
            end
            if (hold > 0) hold--;
            cyc($urandom_range(0, 39) == 0, (hold > 0) ? hv : 10'h000,
                $urandom_range(0, 119) == 0);
        end

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
